dram_arbiter: RTL and testbench
===============================

DRAM_ARBITER -- requirements
Module: dram_arbiter

Interface
REQ-001 SHALL have parameter: XLEN, 32, data/address width; only 32 supported.
REQ-002 SHALL have port: clk_i  input  1  clock; all state changes on rising edge.
REQ-003 SHALL have port: rst_i  input  1  reset; synchronous, active-high.
REQ-004 SHALL have per requester p in {0=core, 1=dbg}: req{p}_i  input  1  access request; held stable until granted.
REQ-005 SHALL have port: we{p}_i  input  1  1=store, 0=load.
REQ-006 SHALL have port: sel{p}_i  input  3  [1:0] 00=B, 01=H, 10=W, 11=reserved; [2] 1=unsigned load.
REQ-007 SHALL have port: addr{p}_i  input  XLEN  byte address.
REQ-008 SHALL have port: wdata{p}_i  input  XLEN  store data, right-aligned.
REQ-009 SHALL have port: gnt{p}_o  output  1  request accepted this cycle.
REQ-010 SHALL have port: rvalid{p}_o  output  1  load data valid, 1-cycle pulse.
REQ-011 SHALL have port: rdata{p}_o  output  XLEN  extended load data.
REQ-012 SHALL have port: err{p}_o  output  1  misaligned/reserved access, 1-cycle pulse.
REQ-013 SHALL have port: dram_en_o  output  1  DRAM command valid.
REQ-014 SHALL have port: dram_wr_byte_en_o  output  4  byte write lanes; 0000 = read.
REQ-015 SHALL have port: dram_addr_o  output  XLEN-2  word address = addr[XLEN-1:2].
REQ-016 SHALL have port: dram_wdata_o  output  XLEN  lane-aligned store data.
REQ-017 SHALL have port: dram_rdata_i  input  XLEN  read word, valid one cycle after read command.

Function
REQ-018 SHALL grant at most one requester per cycle, combinationally, in the cycle req is high.
REQ-019 SHALL arbitrate round-robin: single requester always wins; on conflict, winner = port not granted last; after reset, port 0 wins first conflict.
REQ-020 SHALL update the last-grant pointer only on a granted, non-error access.
REQ-021 SHALL flag error, with gnt asserted, dram_en_o=0, err pulse same cycle, when: sel[1:0]=11; H with addr[0]=1; W with addr[1:0]!=00.
REQ-022 SHALL, on a valid grant, drive dram_en_o=1, dram_addr_o from granted addr, same cycle.
REQ-023 SHALL generate store lanes: B -> 0001<<addr[1:0]; H -> 0011<<addr[1:0]; W -> 1111; loads -> 0000.
REQ-024 SHALL replicate store data: B -> byte x4; H -> halfword x2; W -> as-is.
REQ-025 SHALL hold a 2-state FSM: IDLE (no load outstanding), RESP (load issued previous cycle); IDLE->RESP on granted load; RESP->RESP on another granted load; RESP->IDLE otherwise; stores never leave IDLE.
REQ-026 SHALL register port, sel, addr[1:0] of each granted load, and in RESP pulse rvalid of that port with dram_rdata_i shifted right by 8*addr[1:0], sign-extended (sel[2]=0) or zero-extended (sel[2]=1) from B/H width.
REQ-027 SHALL accept a new grant in RESP state (back-to-back, 1 access/cycle throughput).
REQ-028 SHALL hold rdata{p}_o at last value when rvalid low.
REQ-029 SHALL drive dram_wr_byte_en_o=0000, dram_wdata_o=0, dram_addr_o=0 when dram_en_o=0.

Reset
REQ-030 SHALL, with rst_i high at an edge: FSM->IDLE, pointer->port 1 last granted, rdata{p}_o->0; rvalid, err, gnt, dram_en_o low during reset cycle.
REQ-031 SHALL drop an outstanding load response when reset asserts in RESP; no rvalid after reset.

Verification
REQ-032 SHALL cover: port0 SB addr 0x103, wdata 0xAB -> gnt0, dram_wr_byte_en_o=1000, dram_wdata_o=0xABABABAB, dram_addr_o=0x40.
REQ-033 SHALL cover: port1 LH addr 0x2, dram_rdata_i=0x8001_0000 next cycle -> rvalid1, rdata1_o=0xFFFF8001; LHU -> 0x00008001.
REQ-034 SHALL cover: both req held 4 cycles after reset -> grants 0,1,0,1; no cycle with both gnt.
REQ-035 SHALL cover: port0 LW addr 0x6 -> gnt0, err0 pulse, dram_en_o=0, pointer unchanged.
REQ-036 SHALL cover: back-to-back LB port0 addr 0x1 then LW port1 addr 0x4 -> rvalid0 cycle T+1 (byte1, sign-extended), rvalid1 T+2.
REQ-037 SHALL cover: reset asserted in RESP cycle -> no rvalid, outputs at reset values next cycle.

Source files
------------

// File: rtl/dram_arbiter.sv
// Two-port (core / debug) arbiter in front of a single-ported word-wide DRAM.
// Grants combinationally with round-robin fairness, aligns store data and byte
// lanes, flags misaligned or reserved accesses, and returns extended load data
// one cycle after the read command.
module dram_arbiter #(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    // requester 0 (core)
    input  logic            req0_i,
    input  logic            we0_i,
    input  logic [2:0]      sel0_i,
    input  logic [XLEN-1:0] addr0_i,
    input  logic [XLEN-1:0] wdata0_i,
    output logic            gnt0_o,
    output logic            rvalid0_o,
    output logic [XLEN-1:0] rdata0_o,
    output logic            err0_o,
    // requester 1 (debug)
    input  logic            req1_i,
    input  logic            we1_i,
    input  logic [2:0]      sel1_i,
    input  logic [XLEN-1:0] addr1_i,
    input  logic [XLEN-1:0] wdata1_i,
    output logic            gnt1_o,
    output logic            rvalid1_o,
    output logic [XLEN-1:0] rdata1_o,
    output logic            err1_o,
    // DRAM side
    output logic            dram_en_o,
    output logic [3:0]      dram_wr_byte_en_o,
    output logic [XLEN-3:0] dram_addr_o,
    output logic [XLEN-1:0] dram_wdata_o,
    input  logic [XLEN-1:0] dram_rdata_i
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RESP = 1'b1
    } state_t;

    // Per-port views of the request buses so the two ports share one decoder
    logic [1:0]      w_req;
    logic            w_we    [2];
    logic [2:0]      w_sel   [2];
    logic [XLEN-1:0] w_addr  [2];
    logic [XLEN-1:0] w_wdata [2];
    logic [1:0]      w_bad;
    logic [1:0]      w_rvalid;
    logic [XLEN-1:0] w_rdata [2];

    assign w_req      = {req1_i, req0_i};
    assign w_we[0]    = we0_i;
    assign w_we[1]    = we1_i;
    assign w_sel[0]   = sel0_i;
    assign w_sel[1]   = sel1_i;
    assign w_addr[0]  = addr0_i;
    assign w_addr[1]  = addr1_i;
    assign w_wdata[0] = wdata0_i;
    assign w_wdata[1] = wdata1_i;

    state_t          r_state;
    logic            r_last;     // index of the port granted most recently
    logic            r_port;     // port owning the outstanding load
    logic [2:0]      r_sel;
    logic [1:0]      r_off;

    logic [1:0]      w_gnt;
    logic            w_win;
    logic            w_valid;
    logic            w_load;
    logic [2:0]      w_s_sel;
    logic [XLEN-1:0] w_s_addr;
    logic [XLEN-1:0] w_s_wdata;
    logic            w_s_we;
    logic [XLEN-1:0] w_shift;
    logic [XLEN-1:0] w_ext;

    // Alignment/reserved-size check, evaluated for both ports in parallel
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_chk
            assign w_bad[gi] = (w_sel[gi][1:0] == 2'b11) ||
                               ((w_sel[gi][1:0] == 2'b01) && w_addr[gi][0]) ||
                               ((w_sel[gi][1:0] == 2'b10) && (w_addr[gi][1:0] != 2'b00));
        end
    endgenerate

    // Round-robin grant: a lone requester always wins, a conflict goes to the
    // port that was not granted last. Nothing is granted while in reset.
    always_comb begin
        w_gnt = 2'b00;
        if (!rst_i) begin
            if (&w_req) begin
                w_gnt[~r_last] = 1'b1;
            end else begin
                w_gnt = w_req;
            end
        end
    end

    assign w_win     = w_gnt[1];
    assign w_s_sel   = w_sel[w_win];
    assign w_s_addr  = w_addr[w_win];
    assign w_s_wdata = w_wdata[w_win];
    assign w_s_we    = w_we[w_win];
    assign w_valid   = (|w_gnt) && !w_bad[w_win];
    assign w_load    = w_valid && !w_s_we;

    assign gnt0_o = w_gnt[0];
    assign gnt1_o = w_gnt[1];
    assign err0_o = w_gnt[0] && w_bad[0];
    assign err1_o = w_gnt[1] && w_bad[1];

    // DRAM command: lanes and replicated data for stores, all-zero when idle
    always_comb begin
        dram_en_o         = 1'b0;
        dram_wr_byte_en_o = 4'b0000;
        dram_addr_o       = '0;
        dram_wdata_o      = '0;
        if (w_valid) begin
            dram_en_o   = 1'b1;
            dram_addr_o = w_s_addr[XLEN-1:2];
            if (w_s_we) begin
                case (w_s_sel[1:0])
                    2'b00: begin
                        dram_wr_byte_en_o = 4'b0001 << w_s_addr[1:0];
                        dram_wdata_o      = {4{w_s_wdata[7:0]}};
                    end
                    2'b01: begin
                        dram_wr_byte_en_o = 4'b0011 << w_s_addr[1:0];
                        dram_wdata_o      = {2{w_s_wdata[15:0]}};
                    end
                    default: begin
                        dram_wr_byte_en_o = 4'b1111;
                        dram_wdata_o      = w_s_wdata;
                    end
                endcase
            end
        end
    end

    // Response FSM: RESP for exactly the cycle after each granted load
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
            r_port  <= 1'b0;
            r_sel   <= 3'b000;
            r_off   <= 2'b00;
        end else if (w_load) begin
            r_state <= S_RESP;
            r_port  <= w_win;
            r_sel   <= w_s_sel;
            r_off   <= w_s_addr[1:0];
        end else begin
            r_state <= S_IDLE;
        end
    end

    // Fairness pointer moves only on accesses that actually reach the DRAM
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_last <= 1'b1;
        end else if (w_valid) begin
            r_last <= w_win;
        end
    end

    // Bring the addressed byte/halfword down to bit 0 and extend it
    assign w_shift = dram_rdata_i >> {r_off, 3'b000};

    always_comb begin
        case (r_sel[1:0])
            2'b00:   w_ext = {{(XLEN-8){~r_sel[2] & w_shift[7]}}, w_shift[7:0]};
            2'b01:   w_ext = {{(XLEN-16){~r_sel[2] & w_shift[15]}}, w_shift[15:0]};
            default: w_ext = w_shift;
        endcase
    end

    // Per-port response pulse and hold register for the last returned data
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_resp
            logic [XLEN-1:0] r_rdata;

            assign w_rvalid[gi] = (r_state == S_RESP) && !rst_i && (r_port == 1'(gi));
            assign w_rdata[gi]  = w_rvalid[gi] ? w_ext : r_rdata;

            // Remember the data so the output holds between pulses
            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    r_rdata <= '0;
                end else if (w_rvalid[gi]) begin
                    r_rdata <= w_ext;
                end
            end
        end
    endgenerate

    assign rvalid0_o = w_rvalid[0];
    assign rvalid1_o = w_rvalid[1];
    assign rdata0_o  = w_rdata[0];
    assign rdata1_o  = w_rdata[1];

endmodule

// File: tb/tb_dram_arbiter.sv
// Self-checking bench for dram_arbiter: directed scenarios followed by a
// randomized run, all judged against a cycle-level behavioural model.
module tb_dram_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0, req1, we0, we1;
    logic [2:0]  sel0, sel1;
    logic [31:0] addr0, addr1, wdata0, wdata1;
    logic        gnt0, gnt1, rvalid0, rvalid1, err0, err1;
    logic [31:0] rdata0, rdata1;
    logic        dram_en;
    logic [3:0]  dram_be;
    logic [29:0] dram_addr;
    logic [31:0] dram_wdata, dram_rdata;

    int n_cmp  = 0;
    int n_fail = 0;

    // model state
    int          m_last;
    bit          m_pend;
    int          m_pport;
    logic [2:0]  m_psel;
    int          m_poff;
    logic [31:0] m_rd [2];
    bit          m_g0, m_g1;

    // last observed values, for directed spot checks
    logic        o_g0, o_g1, o_err0, o_en, o_rv0, o_rv1;
    logic [3:0]  o_be;
    logic [29:0] o_addr;
    logic [31:0] o_wd, o_rd0, o_rd1;

    always #5 clk = ~clk;

    dram_arbiter #(.XLEN(32)) dut (
        .clk_i(clk), .rst_i(rst),
        .req0_i(req0), .we0_i(we0), .sel0_i(sel0), .addr0_i(addr0), .wdata0_i(wdata0),
        .gnt0_o(gnt0), .rvalid0_o(rvalid0), .rdata0_o(rdata0), .err0_o(err0),
        .req1_i(req1), .we1_i(we1), .sel1_i(sel1), .addr1_i(addr1), .wdata1_i(wdata1),
        .gnt1_o(gnt1), .rvalid1_o(rvalid1), .rdata1_o(rdata1), .err1_o(err1),
        .dram_en_o(dram_en), .dram_wr_byte_en_o(dram_be), .dram_addr_o(dram_addr),
        .dram_wdata_o(dram_wdata), .dram_rdata_i(dram_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_p(input int p, input bit rq, input bit w, input logic [2:0] s,
                         input logic [31:0] a, input logic [31:0] d);
        if (p == 0) begin
            req0 = rq; we0 = w; sel0 = s; addr0 = a; wdata0 = d;
        end else begin
            req1 = rq; we1 = w; sel1 = s; addr1 = a; wdata1 = d;
        end
    endtask

    task automatic idle();
        set_p(0, 0, 0, 3'b000, 32'h0, 32'h0);
        set_p(1, 0, 0, 3'b000, 32'h0, 32'h0);
    endtask

    // Value a load of size/signedness s at byte offset off returns from word w
    function automatic logic [31:0] load_value(input logic [31:0] w, input logic [2:0] s, input int off);
        logic [31:0] v;
        v = w / (32'd1 << (8 * off));
        if (s[1:0] == 2'b00) begin
            v = v % 32'd256;
            if (!s[2] && v >= 32'd128) v = v + 32'hFFFF_FF00;
        end else if (s[1:0] == 2'b01) begin
            v = v % 32'd65536;
            if (!s[2] && v >= 32'd32768) v = v + 32'hFFFF_0000;
        end
        return v;
    endfunction

    // One clock cycle: predict every output, compare at the falling edge,
    // advance the model, and return just after the next rising edge.
    task automatic cycle(input bit do_check);
        int          win, sz, off;
        bit          bad, w;
        logic [2:0]  s;
        logic [31:0] a, d, v;
        logic        e_g0, e_g1, e_err0, e_err1, e_en, e_rv0, e_rv1;
        logic [3:0]  e_be;
        logic [29:0] e_addr;
        logic [31:0] e_wd, e_rd0, e_rd1;
        @(negedge clk);
        e_g0 = 0; e_g1 = 0; e_err0 = 0; e_err1 = 0; e_en = 0; e_rv0 = 0; e_rv1 = 0;
        e_be = 0; e_addr = 0; e_wd = 0; e_rd0 = m_rd[0]; e_rd1 = m_rd[1];
        win = -1; w = 0; v = 0;
        if (!rst) begin
            if (m_pend) begin
                v = load_value(dram_rdata, m_psel, m_poff);
                if (m_pport == 0) begin e_rv0 = 1; e_rd0 = v; end
                else              begin e_rv1 = 1; e_rd1 = v; end
            end
            if (req0 && req1) win = (m_last == 0) ? 1 : 0;
            else if (req0)    win = 0;
            else if (req1)    win = 1;
            if (win >= 0) begin
                s = (win == 0) ? sel0 : sel1;
                a = (win == 0) ? addr0 : addr1;
                d = (win == 0) ? wdata0 : wdata1;
                w = (win == 0) ? we0 : we1;
                sz = s[1:0];
                off = a % 4;
                bad = (sz == 3) || (sz == 1 && (a % 2) != 0) || (sz == 2 && off != 0);
                if (win == 0) e_g0 = 1; else e_g1 = 1;
                if (bad) begin
                    if (win == 0) e_err0 = 1; else e_err1 = 1;
                end else begin
                    e_en = 1;
                    e_addr = 30'(a / 4);
                    if (w) begin
                        if (sz == 0) begin
                            e_be = 4'(1 << off);
                            e_wd = (d % 32'd256) * 32'h0101_0101;
                        end else if (sz == 1) begin
                            e_be = 4'(3 << off);
                            e_wd = (d % 32'd65536) * 32'h0001_0001;
                        end else begin
                            e_be = 4'hF;
                            e_wd = d;
                        end
                    end
                end
            end
        end
        o_g0 = gnt0; o_g1 = gnt1; o_err0 = err0; o_en = dram_en; o_be = dram_be;
        o_addr = dram_addr; o_wd = dram_wdata; o_rv0 = rvalid0; o_rv1 = rvalid1;
        o_rd0 = rdata0; o_rd1 = rdata1;
        if (do_check) begin
            chk("gnt0", 32'(gnt0), 32'(e_g0));
            chk("gnt1", 32'(gnt1), 32'(e_g1));
            chk("err0", 32'(err0), 32'(e_err0));
            chk("err1", 32'(err1), 32'(e_err1));
            chk("dram_en", 32'(dram_en), 32'(e_en));
            chk("dram_be", 32'(dram_be), 32'(e_be));
            chk("dram_addr", 32'(dram_addr), 32'(e_addr));
            chk("dram_wdata", dram_wdata, e_wd);
            chk("rvalid0", 32'(rvalid0), 32'(e_rv0));
            chk("rvalid1", 32'(rvalid1), 32'(e_rv1));
            chk("rdata0", rdata0, e_rd0);
            chk("rdata1", rdata1, e_rd1);
        end
        m_g0 = e_g0; m_g1 = e_g1;
        if (rst) begin
            m_last = 1; m_pend = 0; m_rd[0] = 0; m_rd[1] = 0;
        end else begin
            if (e_rv0) m_rd[0] = e_rd0;
            if (e_rv1) m_rd[1] = e_rd1;
            m_pend = e_en && !w;
            if (m_pend) begin
                m_pport = win; m_psel = s; m_poff = off;
            end
            if (e_en) m_last = win;
        end
        $display("cyc rst=%0b req=%0b%0b gnt=%0b%0b err=%0b%0b en=%0b be=%b addr=%h wd=%h rv=%0b%0b rd0=%h rd1=%h",
                 rst, req1, req0, gnt1, gnt0, err1, err0, dram_en, dram_be, dram_addr,
                 dram_wdata, rvalid1, rvalid0, rdata0, rdata1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        m_last = 1; m_pend = 0; m_pport = 0; m_psel = 0; m_poff = 0;
        m_rd[0] = 0; m_rd[1] = 0;
        rst = 1; dram_rdata = 32'h0;
        idle();
        @(posedge clk); #1;

        // reset: first cycle settles the registers, second is checked
        cycle(0);
        req0 = 1; req1 = 1;
        cycle(1);
        chk("rst_gnt0", 32'(o_g0), 32'd0);
        chk("rst_rdata0", o_rd0, 32'd0);
        rst = 0;

        // both requesters held for four cycles: grants alternate 0,1,0,1
        set_p(0, 1, 1, 3'b010, 32'h10, 32'h1111_1111);
        set_p(1, 1, 1, 3'b010, 32'h20, 32'h2222_2222);
        for (int i = 0; i < 4; i++) begin
            cycle(1);
            chk("rr_gnt0", 32'(o_g0), (i % 2 == 0) ? 32'd1 : 32'd0);
            chk("rr_gnt1", 32'(o_g1), (i % 2 == 0) ? 32'd0 : 32'd1);
        end
        idle();

        // store byte at 0x103
        set_p(0, 1, 1, 3'b000, 32'h103, 32'hAB);
        cycle(1);
        chk("sb_be", 32'(o_be), 32'b1000);
        chk("sb_wdata", o_wd, 32'hABAB_ABAB);
        chk("sb_addr", 32'(o_addr), 32'h40);
        idle();

        // signed then unsigned halfword load from 0x2 on port 1
        set_p(1, 1, 0, 3'b001, 32'h2, 32'h0);
        cycle(1);
        idle(); dram_rdata = 32'h8001_0000;
        cycle(1);
        chk("lh_rvalid1", 32'(o_rv1), 32'd1);
        chk("lh_rdata1", o_rd1, 32'hFFFF_8001);
        set_p(1, 1, 0, 3'b101, 32'h2, 32'h0);
        dram_rdata = 32'h0;
        cycle(1);
        idle(); dram_rdata = 32'h8001_0000;
        cycle(1);
        chk("lhu_rdata1", o_rd1, 32'h0000_8001);
        dram_rdata = 32'h0;

        // misaligned word load: error, no command, pointer untouched
        set_p(0, 1, 0, 3'b010, 32'h6, 32'h0);
        cycle(1);
        chk("lw_err0", 32'(o_err0), 32'd1);
        chk("lw_en", 32'(o_en), 32'd0);
        set_p(0, 1, 1, 3'b010, 32'h8, 32'h5);
        set_p(1, 1, 1, 3'b010, 32'hC, 32'h6);
        cycle(1);
        chk("ptr_gnt0", 32'(o_g0), 32'd1);
        idle();

        // back-to-back loads on alternate ports
        set_p(0, 1, 0, 3'b000, 32'h1, 32'h0);
        cycle(1);
        idle();
        set_p(1, 1, 0, 3'b010, 32'h4, 32'h0);
        dram_rdata = 32'h1234_F056;
        cycle(1);
        chk("b2b_rv0", 32'(o_rv0), 32'd1);
        chk("b2b_rd0", o_rd0, 32'hFFFF_FFF0);
        idle();
        dram_rdata = 32'hCAFE_BABE;
        cycle(1);
        chk("b2b_rv1", 32'(o_rv1), 32'd1);
        chk("b2b_rd1", o_rd1, 32'hCAFE_BABE);

        // reset during the response cycle drops the response
        set_p(0, 1, 0, 3'b010, 32'h0, 32'h0);
        cycle(1);
        idle(); rst = 1; dram_rdata = 32'h7777_7777;
        cycle(1);
        chk("rstresp_rv0", 32'(o_rv0), 32'd0);
        rst = 0;
        cycle(1);
        chk("rstresp_rv0_after", 32'(o_rv0), 32'd0);
        chk("rstresp_rd0", o_rd0, 32'd0);

        // randomized traffic; a requester keeps its request until granted
        for (int i = 0; i < 1500; i++) begin
            rst = ($urandom_range(0, 63) == 0);
            dram_rdata = $urandom;
            if (!(req0 && !m_g0))
                set_p(0, $urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1,
                      3'($urandom_range(0, 7)), $urandom & 32'h0000_FFFF, $urandom);
            if (!(req1 && !m_g1))
                set_p(1, $urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1,
                      3'($urandom_range(0, 7)), $urandom & 32'h0000_FFFF, $urandom);
            cycle(1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
